// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIter,
        StFix,
        StDone
    } div_state_e;

    localparam int unsigned DivWidth = 16;
    localparam int unsigned PW       = DivWidth + 4;

    // Partial remainder carries four guard bits so add/sub spans whole CLA slices.
    function automatic int unsigned div_pw(input int unsigned width);
        return width + 4;
    endfunction

    function automatic int unsigned div_clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << res) < value) begin
                res = res + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bit4_cla.sv
// 4-bit carry-lookahead adder slice.
module bit4_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];

endmodule

// File: rtl/div_addsub.sv
// PW-bit adder/subtractor built from rippled 4-bit CLA slices (sub: a - b).
module div_addsub #(
    parameter int unsigned PW = 20
) (
    input  logic [PW-1:0] i_a,
    input  logic [PW-1:0] i_b,
    input  logic          i_sub,
    output logic [PW-1:0] o_sum
);

    localparam int unsigned NumSlices = PW / 4;

    logic [PW-1:0]      w_bx;
    logic [NumSlices:0] w_c;
    logic               w_unused_cout;

    assign w_bx          = i_b ^ {PW{i_sub}};
    assign w_c[0]        = i_sub;
    assign w_unused_cout = w_c[NumSlices];

    for (genvar gi = 0; gi < NumSlices; gi++) begin : g_slice
        bit4_cla u_cla (
            .i_a    (i_a[4*gi +: 4]),
            .i_b    (w_bx[4*gi +: 4]),
            .i_cin  (w_c[gi]),
            .o_sum  (o_sum[4*gi +: 4]),
            .o_cout (w_c[gi+1])
        );
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring signed divider: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up step.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int unsigned PartW = div_pw(WIDTH);
    localparam int unsigned CntW  = div_clog2(WIDTH);

    div_state_e r_state, w_state_next;

    logic [WIDTH-1:0] r_a, r_b;
    logic [PartW-1:0] r_p;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CntW-1:0]  r_cnt;
    logic             r_sign_q, r_sign_r;
    logic [WIDTH-1:0] r_quot, r_rem;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_rem_mag;
    logic [PartW-1:0] w_shift, w_add_a, w_add_b, w_sum;
    logic             w_add_sub;

    assign w_a_abs = r_a[WIDTH-1] ? (~r_a + {{(WIDTH-1){1'b0}}, 1'b1}) : r_a;
    assign w_b_abs = r_b[WIDTH-1] ? (~r_b + {{(WIDTH-1){1'b0}}, 1'b1}) : r_b;

    // Shared add/sub: trial step during ITER, remainder restore during FIX.
    assign w_shift   = {r_p[PartW-2:0], r_q[WIDTH-1]};
    assign w_add_a   = (r_state == StFix) ? r_p : w_shift;
    assign w_add_b   = {{(PartW-WIDTH){1'b0}}, r_d};
    assign w_add_sub = (r_state == StIter) && !r_p[PartW-1];
    assign w_rem_mag = r_p[PartW-1] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];

    div_addsub #(
        .PW (PartW)
    ) u_addsub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_sub (w_add_sub),
        .o_sum (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StLoad;
            StLoad: w_state_next = (r_b == '0) ? StDone : StIter;
            StIter: if (r_cnt == '0) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a   <= i_dividend;
                        r_b   <= i_divisor;
                        r_dbz <= 1'b0;
                    end
                end
                StLoad: begin
                    r_p      <= '0;
                    r_q      <= w_a_abs;
                    r_d      <= w_b_abs;
                    r_cnt    <= CntW'(WIDTH - 1);
                    r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_sign_r <= r_a[WIDTH-1];
                    if (r_b == '0) begin
                        r_quot <= '1;
                        r_rem  <= r_a;
                        r_dbz  <= 1'b1;
                    end
                end
                StIter: begin
                    r_p   <= w_sum;
                    r_q   <= {r_q[WIDTH-2:0], ~w_sum[PartW-1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                StFix: begin
                    r_quot <= r_sign_q ? (~r_q + {{(WIDTH-1){1'b0}}, 1'b1}) : r_q;
                    r_rem  <= r_sign_r ? (~w_rem_mag + {{(WIDTH-1){1'b0}}, 1'b1}) : w_rem_mag;
                end
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state == StLoad) || (r_state == StIter) || (r_state == StFix);
    assign o_done        = (r_state == StDone);
    assign o_quotient    = r_quot;
    assign o_remainder   = r_rem;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an integer-arithmetic model.
module tb_seq_divider;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dvd, dvs;
    logic             busy, done, dbz;
    logic [WIDTH-1:0] quot, rem;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] prev_q, prev_r;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quot),
        .o_remainder   (rem),
        .o_div_by_zero (dbz)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truncating integer division; remainder takes the dividend's sign.
    task automatic ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                           output logic z);
        int ai, bi;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = WIDTH'(ai / bi);
            r = WIDTH'(ai % bi);
            z = 1'b0;
        end
    endtask

    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int poke);
        logic [WIDTH-1:0] eq, er;
        logic             ez;
        int               cyc, lat;
        string            id;
        ref_div(a, b, eq, er, ez);
        lat = (b == '0) ? 2 : WIDTH + 3;
        id  = $sformatf("%0d/%0d", $signed(a), $signed(b));
        @(negedge clk);
        start = 1'b1;
        dvd   = a;
        dvs   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dvd   = WIDTH'($urandom);
        dvs   = WIDTH'($urandom);
        cyc   = 1;
        check_eq({"busy_accept ", id}, busy, 1);
        check_eq({"quot_held ", id}, quot, prev_q);
        check_eq({"rem_held ", id}, rem, prev_r);
        check_eq({"dbz_cleared ", id}, dbz, 0);
        while (!done && cyc < 200) begin
            if (cyc == poke) begin
                start = 1'b1;
                dvd   = 16'd3;
                dvs   = 16'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_eq({"latency ", id}, cyc, lat);
        check_eq({"busy_done ", id}, busy, 0);
        check_eq({"quot ", id}, quot, eq);
        check_eq({"rem ", id}, rem, er);
        check_eq({"dbz ", id}, dbz, ez);
        @(posedge clk);
        #1;
        check_eq({"done_pulse ", id}, done, 0);
        check_eq({"quot_after ", id}, quot, eq);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_quot", quot, 0);
        check_eq("reset_rem", rem, 0);
        check_eq("reset_dbz", dbz, 0);
        rst    = 1'b0;
        prev_q = '0;
        prev_r = '0;

        run_div(16'd100, 16'd7, -1);
        run_div(-16'sd100, 16'd7, -1);
        run_div(16'd100, -16'sd7, -1);
        run_div(-16'sd100, -16'sd7, -1);
        run_div(16'd1234, 16'd0, -1);
        run_div(16'd9, 16'd3, -1);
        run_div(16'h8000, 16'hFFFF, -1);
        run_div(16'd5, 16'd9, -1);
        run_div(16'h7FFF, 16'd1, -1);
        run_div(16'h8000, 16'd1, -1);
        run_div(16'h8000, 16'h8000, -1);
        run_div(16'hFFFF, 16'h8000, -1);
        run_div(16'd0, -16'sd5, -1);
        run_div(16'd1000, 16'd7, 5);
        run_div(-16'sd30000, 16'd0, -1);

        // Reset during ITER cycle 5 discards the operation.
        @(negedge clk);
        start = 1'b1;
        dvd   = 16'd100;
        dvs   = 16'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_quot", quot, 0);
        check_eq("rst_mid_rem", rem, 0);
        check_eq("rst_mid_dbz", dbz, 0);
        rst    = 1'b0;
        prev_q = '0;
        prev_r = '0;
        run_div(16'd100, 16'd7, -1);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = WIDTH'($urandom);
                1:       rb = WIDTH'($urandom_range(1, 15));
                2:       rb = -WIDTH'($urandom_range(1, 300));
                default: rb = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom_range(1, 2000));
            endcase
            run_div(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 17)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
